// File: rtl/isolde_vli_pkg.sv
// Purpose: shared types, opcodes and header length decode for the VLI collector.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package isolde_vli_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    ISSUE
  } vli_state_e;

  localparam logic [6:0] OPC_VLI1 = 7'h0B;
  localparam logic [6:0] OPC_VLI2 = 7'h2B;
  localparam logic [6:0] OPC_VLIN = 7'h5B;

  // Raw instruction length in words from the header opcode; 0 means illegal.
  // The upper bound against the configured buffer depth is checked by the user.
  function automatic logic [3:0] vli_len(input logic [31:0] hdr);
    logic [3:0] len;
    len = 4'd0;
    case (hdr[6:0])
      OPC_VLI1: len = 4'd1;
      OPC_VLI2: len = 4'd2;
      OPC_VLIN: len = {1'b0, hdr[14:12]} + 4'd1;
      default:  len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/isolde_vli_collector.sv
// Purpose: collects a variable-length instruction word by word and issues it whole.
// Latency: instr_valid_o rises the cycle after the last word is accepted (N cycles for N words).
// Backpressure: fetch stalls only while a complete instruction waits for instr_ready_i.
module isolde_vli_collector
  import isolde_vli_pkg::*;
#(
  parameter int MaxWords = 5,
  localparam int LenW    = $clog2(MaxWords + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  fetch_valid_i,
  input  logic [31:0]           fetch_word_i,
  output logic                  fetch_ready_o,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [MaxWords*32-1:0] instr_words_o,
  output logic [LenW-1:0]       instr_len_o,
  output logic                  illegal_o,
  output logic                  busy_o
);

  vli_state_e            state_q, state_d;
  logic [LenW-1:0]       count_q;
  logic [LenW-1:0]       len_q;
  logic [LenW-1:0]       count_inc;
  logic [MaxWords*32-1:0] buf_q;
  logic                  illegal_q;

  logic                  fetch_fire;
  logic                  issue_fire;
  logic                  hdr_take;
  logic                  hdr_legal;
  logic [3:0]            hdr_raw;
  logic [LenW-1:0]       hdr_len;
  vli_state_e            hdr_next;

  // Decode the incoming word as if it were a header; only used when a header is expected.
  always_comb begin
    hdr_raw   = vli_len(fetch_word_i);
    hdr_legal = (hdr_raw != 4'd0) && (hdr_raw <= 4'(MaxWords));
    hdr_len   = LenW'(hdr_raw);
    hdr_next  = IDLE;
    if (hdr_legal) begin
      hdr_next = (hdr_len == LenW'(1)) ? ISSUE : COLLECT;
    end
  end

  // State register; reset drops everything immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Handshake outputs and next state; a header may be taken in IDLE or on the issue cycle.
  always_comb begin
    fetch_ready_o = 1'b1;
    instr_valid_o = 1'b0;
    busy_o        = 1'b1;
    state_d       = state_q;
    count_inc     = count_q + LenW'(1);

    case (state_q)
      IDLE:    busy_o = 1'b0;
      COLLECT: fetch_ready_o = 1'b1;
      ISSUE: begin
        instr_valid_o = 1'b1;
        fetch_ready_o = instr_ready_i;
      end
      default: busy_o = 1'b0;
    endcase

    fetch_fire = fetch_valid_i && fetch_ready_o;
    issue_fire = instr_valid_o && instr_ready_i;
    hdr_take   = fetch_fire && ((state_q == IDLE) || issue_fire);

    case (state_q)
      IDLE: begin
        if (hdr_take) state_d = hdr_next;
      end
      COLLECT: begin
        if (fetch_fire && (count_inc == len_q)) state_d = ISSUE;
      end
      ISSUE: begin
        if (issue_fire) state_d = hdr_take ? hdr_next : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (flush_i) state_d = IDLE;
  end

  // Word buffer, length, count and the illegal-header pulse; flush discards handshakes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q     <= '0;
      len_q     <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else if (flush_i) begin
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      illegal_q <= hdr_take && !hdr_legal;
      if (hdr_take && hdr_legal) begin
        buf_q   <= (MaxWords*32)'(fetch_word_i);
        len_q   <= hdr_len;
        count_q <= LenW'(1);
      end else if (fetch_fire && (state_q == COLLECT)) begin
        for (int k = 1; k < MaxWords; k++) begin
          if (count_q == LenW'(k)) buf_q[k*32 +: 32] <= fetch_word_i;
        end
        count_q <= count_inc;
      end else if (issue_fire) begin
        count_q <= '0;
      end
    end
  end

  assign instr_words_o = buf_q;
  assign instr_len_o   = len_q;
  assign illegal_o     = illegal_q;

endmodule
